// File: rtl/conv3x3_filt_if.sv
// Pixel types shared by the filter and its neighbours, plus the valid/ready stream interface.
// Stream interface: ok marks a completed transfer (vld & rdy) on the current clock.
package pixel_pkg;
    typedef logic [7:0]         chan_t;
    typedef chan_t [2:0]        pixel_t;   // [0]=R [1]=G [2]=B
    typedef pixel_t [2:0][2:0]  chunk_t;   // chunk[row][col]
endpackage

interface conv3x3_filt_if #(parameter int W = 24);
    logic [W-1:0] data;
    logic         vld;
    logic         rdy;
    logic         ok;

    assign ok = vld & rdy;

    modport master (output data, vld, input rdy, ok);
    modport slave  (input data, vld, ok, output rdy);
endinterface

// File: rtl/conv3x3_filt.sv
// Programmable 3x3 convolution on R/G/B windows, 4-stage pipeline, one window per clock.
// Optional macro FILT_BYPASS_EN adds a per-window bypass that forwards the centre pixel.
module conv3x3_filt #(
    parameter int COEF_W  = 8,
    parameter int SHIFT_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    done,
    input  logic [8:0][COEF_W-1:0]  coef_i,
    input  logic [SHIFT_W-1:0]      shift_i,
`ifdef FILT_BYPASS_EN
    input  logic                    bypass,
`endif
    conv3x3_filt_if.slave           axis_i,
    conv3x3_filt_if.master          axis_o,
    output logic [31:0]             pix_cnt
);
    import pixel_pkg::*;

    localparam int PROD_W = COEF_W + 9;
    localparam int ROW_W  = PROD_W + 2;
    localparam int SUM_W  = PROD_W + 4;

    function automatic chan_t rnd_sat(input logic signed [SUM_W-1:0] sum,
                                      input logic [SHIFT_W-1:0] sh);
        logic signed [SUM_W:0] v;
        v = (SUM_W+1)'(sum);
        if (sh != '0)
            v = v + $signed((SUM_W+1)'(1) << (sh - 1'b1));
        v = v >>> sh;
        if (v[SUM_W])
            rnd_sat = 8'd0;
        else if (v > (SUM_W+1)'(255))
            rnd_sat = 8'd255;
        else
            rnd_sat = v[7:0];
    endfunction

    logic                       w_en;
    chunk_t                     w_chunk;

    logic signed [COEF_W-1:0]   r_coef [9];
    logic [SHIFT_W-1:0]         r_shift;

    logic                       r_vld_p1, r_vld_p2, r_vld_p3, r_vld_o;
    logic signed [PROD_W-1:0]   r_prod_p1 [3][9];
    logic signed [ROW_W-1:0]    r_row_p2  [3][3];
    logic signed [SUM_W-1:0]    r_sum_p3  [3];
    logic [SHIFT_W-1:0]         r_shift_p1, r_shift_p2, r_shift_p3;
    pixel_t                     r_data_o;
    logic [31:0]                r_pix_cnt;
`ifdef FILT_BYPASS_EN
    logic                       r_byp_p1, r_byp_p2, r_byp_p3;
    pixel_t                     r_ctr_p1, r_ctr_p2, r_ctr_p3;
`endif

    assign w_chunk     = axis_i.data;
    assign w_en        = ~r_vld_o | axis_o.rdy;
    assign axis_i.rdy  = w_en;
    assign axis_o.vld  = r_vld_o;
    assign axis_o.data = r_data_o;
    assign pix_cnt     = r_pix_cnt;

    // Active kernel: swapped only at end of frame so a frame never mixes kernels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++)
                r_coef[k] <= '0;
            r_coef[4] <= COEF_W'(1);
            r_shift   <= '0;
        end else if (done) begin
            for (int k = 0; k < 9; k++)
                r_coef[k] <= $signed(coef_i[k]);
            r_shift <= shift_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
            r_vld_o  <= 1'b0;
        end else if (w_en) begin
            r_vld_p1 <= axis_i.ok;
            r_vld_p2 <= r_vld_p1;
            r_vld_p3 <= r_vld_p2;
            r_vld_o  <= r_vld_p3;
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            // S1: products with the kernel active at entry; shift travels with the window
            for (int c = 0; c < 3; c++)
                for (int k = 0; k < 9; k++)
                    r_prod_p1[c][k] <= PROD_W'($signed({1'b0, w_chunk[k/3][k%3][c]}))
                                     * PROD_W'(r_coef[k]);
            r_shift_p1 <= r_shift;
            // S2: row sums
            for (int c = 0; c < 3; c++)
                for (int r = 0; r < 3; r++)
                    r_row_p2[c][r] <= ROW_W'(r_prod_p1[c][3*r])
                                    + ROW_W'(r_prod_p1[c][3*r+1])
                                    + ROW_W'(r_prod_p1[c][3*r+2]);
            r_shift_p2 <= r_shift_p1;
            // S3: window total
            for (int c = 0; c < 3; c++)
                r_sum_p3[c] <= SUM_W'(r_row_p2[c][0])
                             + SUM_W'(r_row_p2[c][1])
                             + SUM_W'(r_row_p2[c][2]);
            r_shift_p3 <= r_shift_p2;
`ifdef FILT_BYPASS_EN
            r_byp_p1 <= bypass;
            r_ctr_p1 <= w_chunk[1][1];
            r_byp_p2 <= r_byp_p1;
            r_ctr_p2 <= r_ctr_p1;
            r_byp_p3 <= r_byp_p2;
            r_ctr_p3 <= r_ctr_p2;
`endif
        end
    end

    // S4: round, normalise, clamp into the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_o <= '0;
        end else if (w_en) begin
`ifdef FILT_BYPASS_EN
            if (r_byp_p3)
                r_data_o <= r_ctr_p3;
            else
                for (int c = 0; c < 3; c++)
                    r_data_o[c] <= rnd_sat(r_sum_p3[c], r_shift_p3);
`else
            for (int c = 0; c < 3; c++)
                r_data_o[c] <= rnd_sat(r_sum_p3[c], r_shift_p3);
`endif
        end
    end

    // A transfer coinciding with done belongs to the new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pix_cnt <= '0;
        else if (done)
            r_pix_cnt <= {31'd0, axis_o.ok};
        else if (axis_o.ok)
            r_pix_cnt <= r_pix_cnt + 32'd1;
    end

endmodule

// File: tb/tb_conv3x3_filt.sv
// Self-checking bench for conv3x3_filt: vector table, streaming under back-pressure,
// kernel swap with windows in flight, and reset mid-stream.
module tb_conv3x3_filt;
    import pixel_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            done;
    logic [8:0][7:0] coef_i;
    logic [3:0]      shift_i;
    logic [31:0]     pix_cnt;
`ifdef FILT_BYPASS_EN
    logic            bypass;
`endif

    conv3x3_filt_if #(.W($bits(chunk_t))) in_if ();
    conv3x3_filt_if #(.W($bits(pixel_t))) out_if ();

    always #5 clk = ~clk;

    conv3x3_filt dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .done    (done),
        .coef_i  (coef_i),
        .shift_i (shift_i),
`ifdef FILT_BYPASS_EN
        .bypass  (bypass),
`endif
        .axis_i  (in_if),
        .axis_o  (out_if),
        .pix_cnt (pix_cnt)
    );

    typedef struct {
        pixel_t exp;
        int     tag;
    } sb_t;

    typedef struct {
        pixel_t ctr;
        pixel_t nbr;
        int     kern;
        int     sh;
        pixel_t exp;
    } vec_t;

    sb_t    sb[$];
    vec_t   tbl[9];
    int     checks = 0;
    int     errors = 0;
    int     outs   = 0;
    int     tag_n  = 0;
    int     cur_k[9];
    int     cur_sh;
    logic   stall_prev;
    pixel_t held;

    function automatic pixel_t px(input int r, input int g, input int b);
        pixel_t p;
        p[0] = 8'(r);
        p[1] = 8'(g);
        p[2] = 8'(b);
        return p;
    endfunction

    function automatic chunk_t mkwin(input pixel_t c, input pixel_t n);
        chunk_t w;
        for (int r = 0; r < 3; r++)
            for (int q = 0; q < 3; q++)
                w[r][q] = n;
        w[1][1] = c;
        return w;
    endfunction

    function automatic chunk_t rndwin();
        chunk_t w;
        for (int r = 0; r < 3; r++)
            for (int q = 0; q < 3; q++)
                for (int ch = 0; ch < 3; ch++)
                    w[r][q][ch] = 8'($urandom_range(0, 255));
        return w;
    endfunction

    task automatic load_kern(input int id, output int k[9]);
        for (int i = 0; i < 9; i++)
            k[i] = (id == 0) ? ((i == 4) ? 1 : 0) :
                   (id == 1) ? 1 :
                               ((i == 4) ? 8 : -1);
    endtask

    function automatic pixel_t model(input chunk_t w, input int k[9], input int sh, input bit byp);
        pixel_t p;
        if (byp)
            return w[1][1];
        for (int ch = 0; ch < 3; ch++) begin
            int s;
            s = 0;
            for (int i = 0; i < 9; i++)
                s += int'(w[i/3][i%3][ch]) * k[i];
            if (sh > 0)
                s += 1 << (sh - 1);
            s = s >>> sh;
            p[ch] = (s < 0) ? 8'd0 : (s > 255) ? 8'd255 : 8'(s);
        end
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        sb_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_vld", 32'(out_if.vld), 32'd1);
                    check("hold_data", 32'(out_if.data), 32'(held));
                end
                stall_prev = out_if.vld && !out_if.rdy;
                held       = out_if.data;
                if (out_if.vld && out_if.rdy) begin
                    outs++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got 0x%0h, expected no transfer", out_if.data);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("out_tag%0d", e.tag), 32'(out_if.data), 32'(e.exp));
                    end
                end
            end
        end
    endtask

    task automatic send(input chunk_t w, input pixel_t exp, input bit byp);
        int n;
        @(negedge clk);
        in_if.data = w;
        in_if.vld  = 1'b1;
`ifdef FILT_BYPASS_EN
        bypass = byp;
`else
        if (byp) $display("bypass requested without FILT_BYPASS_EN");
`endif
        n = 0;
        while (!in_if.rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got rdy=0 for 100 clk, expected rdy=1");
            in_if.vld = 1'b0;
            return;
        end
        sb.push_back('{exp, tag_n});
        tag_n++;
        @(posedge clk);
        #1;
        in_if.vld = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_if.vld) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic commit(input int k[9], input int sh);
        @(negedge clk);
        for (int i = 0; i < 9; i++)
            coef_i[i] = 8'(k[i]);
        shift_i = 4'(sh);
        done    = 1'b1;
        @(posedge clk);
        cur_k  = k;
        cur_sh = sh;
        #1;
        done = 1'b0;
        @(negedge clk);
        check("pix_cnt_after_done", pix_cnt, 32'd0);
    endtask

    initial begin
        int     k[9];
        int     lat;
        int     base;
        bit     pat[4];
        bit     vld_seen;
        chunk_t w;

        tbl[0] = '{px(10, 20, 30),    px(99, 77, 55),    0, 0, px(10, 20, 30)};
        tbl[1] = '{px(200, 8, 0),     px(200, 8, 0),     1, 3, px(225, 9, 0)};
        tbl[2] = '{px(0, 0, 0),       px(255, 255, 255), 2, 0, px(0, 0, 0)};
        tbl[3] = '{px(255, 255, 255), px(0, 0, 0),       2, 0, px(255, 255, 255)};
        tbl[4] = '{px(100, 50, 3),    px(90, 50, 4),     2, 0, px(80, 0, 0)};
        tbl[5] = '{px(1, 2, 3),       px(1, 2, 3),       1, 4, px(1, 1, 2)};
        tbl[6] = '{px(1, 0, 0),       px(0, 0, 0),       1, 1, px(1, 0, 0)};
        tbl[7] = '{px(3, 4, 5),       px(0, 0, 0),       0, 1, px(2, 2, 3)};
        tbl[8] = '{px(1, 0, 0),       px(0, 1, 0),       2, 2, px(2, 0, 0)};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst_n       = 1'b0;
        done        = 1'b0;
        coef_i      = '0;
        shift_i     = '0;
        in_if.data  = '0;
        in_if.vld   = 1'b0;
        out_if.rdy  = 1'b1;
        stall_prev  = 1'b0;
        held        = '0;
`ifdef FILT_BYPASS_EN
        bypass = 1'b0;
`endif
        load_kern(0, cur_k);
        cur_sh = 0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_vld", 32'(out_if.vld), 32'd0);
        check("reset_data", 32'(out_if.data), 32'd0);
        check("reset_pix_cnt", pix_cnt, 32'd0);

        // Identity kernel out of reset, before any commit
        send(mkwin(tbl[0].ctr, tbl[0].nbr), tbl[0].exp, 1'b0);
        lat = 0;
        vld_seen = 1'b0;
        while (!vld_seen && lat < 10) begin
            @(negedge clk);
            lat++;
            vld_seen = out_if.vld;
        end
        check("latency_reset_kernel", 32'(lat), 32'd4);
        drain();

        for (int i = 0; i < 9; i++) begin
            load_kern(tbl[i].kern, k);
            commit(k, tbl[i].sh);
            send(mkwin(tbl[i].ctr, tbl[i].nbr), tbl[i].exp, 1'b0);
            lat = 0;
            vld_seen = 1'b0;
            while (!vld_seen && lat < 10) begin
                @(negedge clk);
                lat++;
                vld_seen = out_if.vld;
            end
            check($sformatf("latency_vec%0d", i), 32'(lat), 32'd4);
            drain();
        end

        // Sixteen random windows with a random kernel under rdy 1,0,0,1 back-pressure
        for (int i = 0; i < 9; i++)
            k[i] = int'($signed(8'($urandom_range(0, 255))));
        commit(k, int'($urandom_range(0, 15)));
        base = outs;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    w = rndwin();
                    send(w, model(w, cur_k, cur_sh, 1'b0), 1'b0);
                end
            end
            begin
                for (int c = 0; c < 80; c++) begin
                    out_if.rdy = pat[c % 4];
                    @(posedge clk);
                    #1;
                end
                out_if.rdy = 1'b1;
            end
        join
        drain();
        check("stream_count", 32'(outs - base), 32'd16);
        check("stream_pix_cnt", pix_cnt, 32'd16);

        // Kernel swap while three windows are in flight
        load_kern(1, k);
        commit(k, 3);
        for (int i = 0; i < 3; i++) begin
            w = rndwin();
            send(w, model(w, cur_k, cur_sh, 1'b0), 1'b0);
        end
        load_kern(0, k);
        commit(k, 0);
        for (int i = 0; i < 2; i++) begin
            w = rndwin();
            send(w, model(w, cur_k, cur_sh, 1'b0), 1'b0);
        end
        drain();
        check("swap_pix_cnt", pix_cnt, 32'd5);

        // done on the same clock as an output transfer
        w = rndwin();
        send(w, model(w, cur_k, cur_sh, 1'b0), 1'b0);
        lat = 0;
        vld_seen = 1'b0;
        while (!vld_seen && lat < 10) begin
            @(negedge clk);
            lat++;
            vld_seen = out_if.vld;
        end
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        check("done_with_ok_pix_cnt", pix_cnt, 32'd1);
        drain();

        // Reset with four windows in flight
        load_kern(2, k);
        commit(k, 2);
        for (int i = 0; i < 4; i++) begin
            w = rndwin();
            send(w, model(w, cur_k, cur_sh, 1'b0), 1'b0);
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_vld", 32'(out_if.vld), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        load_kern(0, cur_k);
        cur_sh = 0;
        for (int i = 0; i < 9; i++)
            coef_i[i] = 8'(cur_k[i]);
        shift_i = '0;
        check("rst_mid_pix_cnt", pix_cnt, 32'd0);
        vld_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vld_seen = vld_seen | out_if.vld;
        end
        check("rst_no_spurious_vld", 32'(vld_seen), 32'd0);
        w = mkwin(px(7, 8, 9), px(50, 60, 70));
        send(w, model(w, cur_k, cur_sh, 1'b0), 1'b0);
        drain();
        check("post_rst_pix_cnt", pix_cnt, 32'd1);

`ifdef FILT_BYPASS_EN
        load_kern(2, k);
        commit(k, 0);
        send(mkwin(px(1, 2, 3), px(200, 200, 200)), px(1, 2, 3), 1'b1);
        drain();
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
